cache_line_store: RTL and testbench



---
 rtl/cache_pkg.sv | 17 +
 rtl/cache_word.sv | 31 +++
 rtl/cache_line_store.sv | 117 +++++++++++
 tb/tb_cache_line_store.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and defaults for the cache line storage blocks.
// The line-fill sequencer state and the byte-lane helper live here.
package cache_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_WORDS  = 4;

  function automatic int lanes(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/cache_word.sv
// One line word: a DATA_W register with per-byte write enables and a
// synchronous active-low clear.
module cache_word
  import cache_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W/8-1:0] byte_we,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  localparam int LANES = lanes(DATA_W);

  logic [DATA_W-1:0] q_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      q_reg <= '0;
    end else begin
      for (int b = 0; b < LANES; b++) begin
        if (byte_we[b]) q_reg[8*b +: 8] <= d[8*b +: 8];
      end
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/cache_line_store.sv
// One cache line: WORDS byte-writable words, valid/dirty status and a
// critical-word-first, wrap-around line-fill sequencer.
module cache_line_store
  import cache_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int WORDS  = DEF_WORDS,
  parameter int IDX_W  = $clog2(WORDS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sel,
  input  logic                mem_write,
  input  logic [DATA_W/8-1:0] byte_en,
  input  logic [IDX_W-1:0]    word_idx,
  input  logic [DATA_W-1:0]   data_in,
  input  logic                miss,
  input  logic                fill_valid,
  input  logic [DATA_W-1:0]   fill_data,
  output logic [DATA_W-1:0]   data_out,
  output logic                line_valid,
  output logic                dirty,
  output logic                busy,
  output logic                fill_done
);

  localparam int LANES = lanes(DATA_W);

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] ptr_reg, ptr_next;
  logic [IDX_W-1:0] cnt_reg, cnt_next;
  logic             valid_reg, valid_next;
  logic             dirty_reg, dirty_next;
  logic             done_reg, done_next;

  logic [LANES-1:0]  we_next [WORDS];
  logic [DATA_W-1:0] wdata_next;
  logic [DATA_W-1:0] word_q [WORDS];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      cnt_reg   <= '0;
      valid_reg <= 1'b0;
      dirty_reg <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      cnt_reg   <= cnt_next;
      valid_reg <= valid_next;
      dirty_reg <= dirty_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    cnt_next   = cnt_reg;
    valid_next = valid_reg;
    dirty_next = dirty_reg;
    done_next  = 1'b0;
    wdata_next = data_in;
    for (int w = 0; w < WORDS; w++) we_next[w] = '0;

    case (state_reg)
      IDLE: begin
        // A miss takes priority over a write hit in the same cycle.
        if (sel && miss) begin
          state_next = FILL;
          ptr_next   = word_idx;
          cnt_next   = '0;
          valid_next = 1'b0;
          dirty_next = 1'b0;
        end else if (sel && mem_write && valid_reg) begin
          we_next[word_idx] = byte_en;
          dirty_next        = 1'b1;
        end
      end
      FILL: begin
        if (fill_valid) begin
          we_next[ptr_reg] = '1;
          wdata_next       = fill_data;
          ptr_next         = ptr_reg + 1'b1;  // natural wrap at WORDS
          cnt_next         = cnt_reg + 1'b1;
          if (cnt_reg == IDX_W'(WORDS - 1)) begin
            state_next = IDLE;
            valid_next = 1'b1;
            done_next  = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  generate
    for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
      cache_word #(.DATA_W(DATA_W)) u_word (
        .clk     (clk),
        .reset   (reset),
        .byte_we (we_next[gi]),
        .d       (wdata_next),
        .q       (word_q[gi])
      );
    end
  endgenerate

  assign data_out   = word_q[word_idx];
  assign line_valid = valid_reg;
  assign dirty      = dirty_reg;
  assign busy       = (state_reg == FILL);
  assign fill_done  = done_reg;

endmodule

// File: tb/tb_cache_line_store.sv
// Self-checking bench: a queue-based line model checked every cycle on the
// default instance, plus a directed wrap-order sweep on a 64-bit, 8-word line.
module tb_cache_line_store;

  localparam int DW = 32, NW = 4, IW = 2;
  localparam int BDW = 64, BNW = 8, BIW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset, sel, mem_write, miss, fill_valid;
  logic [DW/8-1:0] byte_en;
  logic [IW-1:0]   word_idx;
  logic [DW-1:0]   data_in, fill_data, data_out;
  logic            line_valid, dirty, busy, fill_done;

  logic             b_reset, b_sel, b_mem_write, b_miss, b_fill_valid;
  logic [BDW/8-1:0] b_byte_en;
  logic [BIW-1:0]   b_word_idx;
  logic [BDW-1:0]   b_data_in, b_fill_data, b_data_out;
  logic             b_line_valid, b_dirty, b_busy, b_fill_done;

  cache_line_store #(.DATA_W(DW), .WORDS(NW)) dut (
    .clk(clk), .reset(reset), .sel(sel), .mem_write(mem_write),
    .byte_en(byte_en), .word_idx(word_idx), .data_in(data_in), .miss(miss),
    .fill_valid(fill_valid), .fill_data(fill_data), .data_out(data_out),
    .line_valid(line_valid), .dirty(dirty), .busy(busy), .fill_done(fill_done)
  );

  cache_line_store #(.DATA_W(BDW), .WORDS(BNW)) dut_b (
    .clk(clk), .reset(b_reset), .sel(b_sel), .mem_write(b_mem_write),
    .byte_en(b_byte_en), .word_idx(b_word_idx), .data_in(b_data_in), .miss(b_miss),
    .fill_valid(b_fill_valid), .fill_data(b_fill_data), .data_out(b_data_out),
    .line_valid(b_line_valid), .dirty(b_dirty), .busy(b_busy), .fill_done(b_fill_done)
  );

  // Line model: word array, status bits, and the list of word slots still to fill.
  logic [DW-1:0] m_word [NW];
  bit m_valid, m_dirty, m_fill, m_done;
  int order[$];

  int pass_cnt = 0, total_cnt = 0;
  bit check_en = 0;
  int busy_seen = 0, done_seen = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic model_update();
    int w;
    if (!reset) begin
      for (int i = 0; i < NW; i++) m_word[i] = '0;
      m_valid = 0; m_dirty = 0; m_fill = 0; m_done = 0;
      order.delete();
    end else begin
      m_done = 0;
      if (m_fill) begin
        if (fill_valid) begin
          w = order.pop_front();
          m_word[w] = fill_data;
          if (order.size() == 0) begin
            m_fill = 0; m_valid = 1; m_done = 1;
          end
        end
      end else if (sel && miss) begin
        order.delete();
        for (int k = 0; k < NW; k++) order.push_back((int'(word_idx) + k) % NW);
        m_fill = 1; m_valid = 0; m_dirty = 0;
      end else if (sel && mem_write && m_valid) begin
        for (int b = 0; b < DW/8; b++)
          if (byte_en[b]) m_word[word_idx][8*b +: 8] = data_in[8*b +: 8];
        m_dirty = 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    if (busy) busy_seen++;
    if (fill_done) done_seen++;
  endtask

  task automatic read_chk(input string name, input int idx, input logic [DW-1:0] exp);
    word_idx = IW'(idx);
    #1;
    chk(name, 64'(data_out), 64'(exp));
  endtask

  task automatic idle_a();
    sel = 0; mem_write = 0; miss = 0; fill_valid = 0;
    byte_en = '0; data_in = '0; fill_data = '0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (check_en) begin
        chk("data_out", 64'(data_out), 64'(m_word[word_idx]));
        chk("line_valid", 64'(line_valid), 64'(m_valid));
        chk("dirty", 64'(dirty), 64'(m_dirty));
        chk("busy", 64'(busy), 64'(m_fill));
        chk("fill_done", 64'(fill_done), 64'(m_done));
      end
    end
  end

  initial begin
    logic [BDW-1:0] bbase;
    bbase = 64'h1000_0000_0000_0000;

    reset = 0; idle_a(); word_idx = '0;
    b_reset = 0; b_sel = 0; b_mem_write = 0; b_miss = 0; b_fill_valid = 0;
    b_byte_en = '0; b_word_idx = '0; b_data_in = '0; b_fill_data = '0;
    tick(); tick();
    reset = 1; b_reset = 1; check_en = 1;
    tick();
    chk("rst_valid", 64'(line_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    $display("txn: reset released");

    // Critical-word-first fill from word 2.
    sel = 1; miss = 1; word_idx = 2; busy_seen = 0; done_seen = 0;
    tick(); miss = 0;
    for (int k = 0; k < 4; k++) begin
      fill_valid = 1; fill_data = 32'hA + k; tick();
    end
    fill_valid = 0;
    chk("fill1_done_pulse", 64'(fill_done), 64'd1);
    tick(); tick();
    chk("fill1_busy_cycles", 64'(busy_seen), 64'd4);
    chk("fill1_done_count", 64'(done_seen), 64'd1);
    read_chk("fill1_w0", 0, 32'hC);
    read_chk("fill1_w1", 1, 32'hD);
    read_chk("fill1_w2", 2, 32'hA);
    read_chk("fill1_w3", 3, 32'hB);
    $display("txn: critical-word fill from idx 2");

    // Byte-enabled write hit.
    word_idx = 1; mem_write = 1; byte_en = 4'hF; data_in = 32'h11223344; tick();
    byte_en = 4'b0101; data_in = 32'hAABBCCDD; tick();
    mem_write = 0;
    read_chk("byte_write_w1", 1, 32'h11BB33DD);
    chk("byte_write_dirty", 64'(dirty), 64'd1);
    $display("txn: byte write hit");

    // Write with sel low is ignored.
    sel = 0; mem_write = 1; byte_en = 4'hF; data_in = 32'hFFFFFFFF; word_idx = 1; tick();
    sel = 1; mem_write = 0;
    read_chk("unsel_write_w1", 1, 32'h11BB33DD);
    chk("unsel_write_dirty", 64'(dirty), 64'd1);
    $display("txn: unselected write ignored");

    // Miss together with write: miss wins; then a stalled fill with writes attempted.
    miss = 1; mem_write = 1; word_idx = 2; busy_seen = 0; done_seen = 0; tick();
    miss = 0;
    read_chk("miss_wins_w2", 2, 32'hA);
    chk("miss_wins_dirty", 64'(dirty), 64'd0);
    chk("miss_wins_busy", 64'(busy), 64'd1);
    fill_valid = 1; fill_data = 32'hA; tick();
    fill_data = 32'hB; tick();
    fill_valid = 0;
    for (int s = 0; s < 3; s++) begin
      word_idx = 3; tick();
    end
    read_chk("stall_w3", 3, 32'hB);
    fill_valid = 1; fill_data = 32'hC; tick();
    fill_data = 32'hD; tick();
    fill_valid = 0; mem_write = 0;
    chk("stall_done_pulse", 64'(fill_done), 64'd1);
    chk("stall_busy_cycles", 64'(busy_seen), 64'd7);
    chk("stall_done_count", 64'(done_seen), 64'd1);
    read_chk("stall_w0", 0, 32'hC);
    read_chk("stall_w1", 1, 32'hD);
    read_chk("stall_w2", 2, 32'hA);
    read_chk("stall_w3b", 3, 32'hB);
    $display("txn: stalled fill with ignored writes");

    // Back-to-back miss in the fill_done cycle, then reset mid-stall.
    miss = 1; word_idx = 0; tick();
    miss = 0;
    chk("b2b_busy", 64'(busy), 64'd1);
    fill_valid = 1; fill_data = 32'h100; tick();
    fill_data = 32'h101; tick();
    fill_valid = 0; tick();
    reset = 0; tick(); tick();
    reset = 1; idle_a(); tick();
    for (int i = 0; i < NW; i++) read_chk("midfill_rst_word", i, 32'h0);
    chk("midfill_rst_valid", 64'(line_valid), 64'd0);
    chk("midfill_rst_busy", 64'(busy), 64'd0);
    $display("txn: back-to-back fill aborted by reset");

    // Write hit on an invalid line is ignored.
    sel = 1; mem_write = 1; byte_en = 4'hF; data_in = 32'h12345678; word_idx = 1; tick();
    mem_write = 0;
    read_chk("invalid_write_w1", 1, 32'h0);
    chk("invalid_write_dirty", 64'(dirty), 64'd0);
    $display("txn: write on invalid line ignored");
    idle_a(); tick();

    // 64-bit, 8-word line filled from the last word.
    b_sel = 1; b_miss = 1; b_word_idx = 7; tick();
    b_miss = 0;
    for (int k = 0; k < BNW; k++) begin
      chk("sweep_busy_during", 64'(b_busy), 64'd1);
      chk("sweep_no_early_done", 64'(b_fill_done), 64'd0);
      b_fill_valid = 1; b_fill_data = bbase + 64'(k); tick();
    end
    b_fill_valid = 0;
    chk("sweep_done", 64'(b_fill_done), 64'd1);
    chk("sweep_busy_after", 64'(b_busy), 64'd0);
    chk("sweep_valid", 64'(b_line_valid), 64'd1);
    for (int k = 0; k < BNW; k++) begin
      b_word_idx = BIW'((7 + k) % BNW);
      #1;
      chk("sweep_word", b_data_out, bbase + 64'(k));
    end
    $display("txn: 64-bit 8-word wrap fill from idx 7");
    tick();

    check_en = 0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
